// File: rtl/pll_freq_meter.sv
// PLL output frequency meter: counts clk_out cycles per (averaged) clk_ref period,
// reports saturating count, signed error against target and a lock indication.
//
// state   | meaning
// IDLE    | waiting for first synchronized ref rise; partial window discarded
// MEASURE | accumulating clk_out cycles over 2^AVG_LOG2 ref periods
module pll_freq_meter #(
  parameter int COUNT_W     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 0,
  parameter int LOCK_N      = 4
) (
  input  logic               clk_out,
  input  logic               rst,
  input  logic               enable,
  input  logic               clk_ref,
  input  logic [COUNT_W-1:0] target,
  input  logic [COUNT_W-1:0] tol,
  output logic [COUNT_W-1:0] count,
  output logic               count_valid,
  output logic               overflow,
  output logic [COUNT_W:0]   error,
  output logic               locked
);

  localparam int ACC_W = COUNT_W + AVG_LOG2;
  localparam int PRD_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PRD_W-1:0] PRD_LAST = PRD_W'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_out_d;
  logic                 ref_rise;
  logic [ACC_W-1:0]     acc, acc_d, acc_inc;
  logic                 acc_sat;
  logic [PRD_W-1:0]     prd_cnt, prd_d;
  logic [3:0]           lock_cnt, lock_inc;
  logic                 win_end;
  logic [COUNT_W-1:0]   cnt_new;
  logic [COUNT_W:0]     err_new, err_abs;
  logic                 in_tol;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sync_out_d <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_ref};
      sync_out_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ref_rise = sync_q[SYNC_STAGES-1] & ~sync_out_d;

  // acc sticks at all-ones once reached, so all-ones doubles as the sat flag
  assign acc_sat = &acc;
  assign acc_inc = acc_sat ? acc : acc + 1'b1;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    prd_d   = prd_cnt;
    win_end = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      prd_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d = '0;
          prd_d = '0;
          if (ref_rise) begin
            state_d = MEASURE;
            acc_d   = ACC_W'(1);
          end
        end
        MEASURE: begin
          if (ref_rise && (prd_cnt == PRD_LAST)) begin
            win_end = 1'b1;
            acc_d   = ACC_W'(1);
            prd_d   = '0;
          end else begin
            acc_d = acc_inc;
            if (ref_rise) prd_d = prd_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_new  = acc_sat ? '1 : acc[ACC_W-1:AVG_LOG2];
    err_new  = {1'b0, cnt_new} - {1'b0, target};
    err_abs  = err_new[COUNT_W] ? -err_new : err_new;
    in_tol   = !acc_sat && (err_abs <= {1'b0, tol});
    lock_inc = (lock_cnt == 4'hf) ? lock_cnt : lock_cnt + 4'd1;
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      prd_cnt     <= '0;
      lock_cnt    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      error       <= '0;
      locked      <= 1'b0;
    end else begin
      acc         <= acc_d;
      prd_cnt     <= prd_d;
      count_valid <= win_end;
      if (win_end) begin
        count    <= cnt_new;
        overflow <= acc_sat;
        error    <= err_new;
        if (in_tol) begin
          lock_cnt <= lock_inc;
          locked   <= (lock_inc >= LOCK_TGT);
        end else begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      end else if (!enable) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_freq_meter.sv
// Self-checking bench for pll_freq_meter: table-driven lock sequence, hand-written
// enable/reset/saturation/averaging sequences, and randomized periods vs a reference model.
module tb_pll_freq_meter;

  localparam int CW = 8;

  logic          clk_out = 1'b0;
  logic          rst, enable, ref0, ref2;
  logic [CW-1:0] target0, tol0, target2, tol2;
  logic [CW-1:0] count0, count2;
  logic          cv0, cv2, ovf0, ovf2, lck0, lck2;
  logic [CW:0]   err0, err2;

  int tests = 0;
  int fails = 0;

  always #5 clk_out = ~clk_out;

  pll_freq_meter #(.COUNT_W(CW), .SYNC_STAGES(2), .AVG_LOG2(0), .LOCK_N(4)) u_avg0 (
    .clk_out(clk_out), .rst(rst), .enable(enable), .clk_ref(ref0),
    .target(target0), .tol(tol0), .count(count0), .count_valid(cv0),
    .overflow(ovf0), .error(err0), .locked(lck0));

  pll_freq_meter #(.COUNT_W(CW), .SYNC_STAGES(2), .AVG_LOG2(2), .LOCK_N(4)) u_avg2 (
    .clk_out(clk_out), .rst(rst), .enable(enable), .clk_ref(ref2),
    .target(target2), .tol(tol2), .count(count2), .count_valid(cv2),
    .overflow(ovf2), .error(err2), .locked(lck2));

  typedef struct {int count; bit ovf; int err; bit locked;} res_t;
  typedef struct {int period; int count; int err; bit locked;} vec_t;

  res_t obs0[$], obs2[$], exp0[$];
  vec_t tbl[9];

  always @(negedge clk_out) begin
    res_t r;
    if (cv0) begin
      r.count = int'(count0); r.ovf = ovf0; r.err = int'($signed(err0)); r.locked = lck0;
      obs0.push_back(r);
    end
    if (cv2) begin
      r.count = int'(count2); r.ovf = ovf2; r.err = int'($signed(err2)); r.locked = lck2;
      obs2.push_back(r);
    end
  end

  task automatic chk(string nm, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic expect_res(int which, string nm, int c, bit o, int e, bit l);
    res_t r;
    bit   empty;
    empty = (which == 0) ? (obs0.size() == 0) : (obs2.size() == 0);
    if (empty) begin
      tests++;
      fails++;
      $display("FAIL %s: no count_valid seen, expected count %0d", nm, c);
    end else begin
      r = (which == 0) ? obs0.pop_front() : obs2.pop_front();
      chk({nm, ".count"}, r.count, c);
      chk({nm, ".ovf"}, int'(r.ovf), int'(o));
      chk({nm, ".err"}, r.err, e);
      chk({nm, ".locked"}, int'(r.locked), int'(l));
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk_out);
  endtask

  // one ref period of n clk_out cycles, rising edge first
  task automatic ref_period(int which, int n);
    if (which == 0) ref0 = 1'b1; else ref2 = 1'b1;
    cycles(n / 2);
    if (which == 0) ref0 = 1'b0; else ref2 = 1'b0;
    cycles(n - n / 2);
  endtask

  // reference model state for the random phase (single-period windows)
  int mdl_lc;

  function automatic res_t model_result(int period, int tgt, int tl);
    res_t r;
    int   full;
    int   mag;
    full = (1 << CW) - 1;
    r.ovf   = (period >= full);
    r.count = r.ovf ? full : period;
    r.err   = r.count - tgt;
    mag     = (r.err < 0) ? -r.err : r.err;
    if (!r.ovf && mag <= tl) mdl_lc = (mdl_lc < 15) ? mdl_lc + 1 : 15;
    else                     mdl_lc = 0;
    r.locked = (mdl_lc >= 4);
    return r;
  endfunction

  initial begin
    bit   active;
    int   last;
    int   n;
    res_t e, g;

    tbl[0] = '{60, 60,  0, 1'b0};
    tbl[1] = '{61, 61,  1, 1'b0};
    tbl[2] = '{59, 59, -1, 1'b0};
    tbl[3] = '{60, 60,  0, 1'b1};
    tbl[4] = '{63, 63,  3, 1'b0};
    tbl[5] = '{60, 60,  0, 1'b0};
    tbl[6] = '{60, 60,  0, 1'b0};
    tbl[7] = '{60, 60,  0, 1'b0};
    tbl[8] = '{60, 60,  0, 1'b1};

    rst = 1'b1; enable = 1'b0; ref0 = 1'b0; ref2 = 1'b0;
    target0 = 8'd60; tol0 = 8'd1; target2 = 8'd62; tol2 = 8'd1;
    #12;
    chk("reset.count", int'(count0), 0);
    chk("reset.valid", int'(cv0), 0);
    chk("reset.ovf", int'(ovf0), 0);
    chk("reset.err", int'(err0), 0);
    chk("reset.locked", int'(lck0), 0);
    cycles(2);
    rst = 1'b0;
    enable = 1'b1;
    cycles(3);

    // table-driven lock sequence
    ref_period(0, tbl[0].period);
    chk("no_valid_first_rise", obs0.size(), 0);
    for (int i = 1; i < 9; i++) ref_period(0, tbl[i].period);
    ref_period(0, 60);
    for (int i = 0; i < 9; i++)
      expect_res(0, $sformatf("tbl%0d", i), tbl[i].count, 1'b0, tbl[i].err, tbl[i].locked);
    chk("tbl.extra", obs0.size(), 0);

    // enable drop while locked
    enable = 1'b0;
    cycles(2);
    chk("dis.locked", int'(lck0), 0);
    chk("dis.count_hold", int'(count0), 60);
    ref_period(0, 50);
    ref_period(0, 50);
    chk("dis.no_valid", obs0.size(), 0);
    chk("dis.count_hold2", int'(count0), 60);
    enable = 1'b1;
    cycles(5);
    ref_period(0, 60);
    chk("reen.no_spurious", obs0.size(), 0);
    ref0 = 1'b1;
    cycles(30);
    expect_res(0, "reen.first", 60, 1'b0, 0, 1'b0);

    // async reset mid-window
    ref0 = 1'b0;
    cycles(3);
    #2 rst = 1'b1;
    #1;
    chk("midrst.count", int'(count0), 0);
    chk("midrst.valid", int'(cv0), 0);
    chk("midrst.ovf", int'(ovf0), 0);
    chk("midrst.err", int'(err0), 0);
    chk("midrst.locked", int'(lck0), 0);
    cycles(3);
    rst = 1'b0;
    cycles(30);
    ref_period(0, 60);
    chk("postrst.no_valid", obs0.size(), 0);
    ref_period(0, 60);
    expect_res(0, "postrst.first", 60, 1'b0, 0, 1'b0);

    // saturation clears the lock streak
    ref_period(0, 300);
    ref_period(0, 60);
    ref_period(0, 60);
    ref_period(0, 60);
    ref_period(0, 60);
    ref_period(0, 60);
    expect_res(0, "sat.pre", 60, 1'b0, 0, 1'b0);
    expect_res(0, "sat.ovf", 255, 1'b1, 195, 1'b0);
    expect_res(0, "sat.post1", 60, 1'b0, 0, 1'b0);
    expect_res(0, "sat.post2", 60, 1'b0, 0, 1'b0);
    expect_res(0, "sat.post3", 60, 1'b0, 0, 1'b0);
    expect_res(0, "sat.post4", 60, 1'b0, 0, 1'b1);

    // averaging over 4 ref periods
    ref_period(2, 60);
    ref_period(2, 61);
    ref_period(2, 60);
    ref_period(2, 61);
    chk("avg.no_intermediate", obs2.size(), 0);
    ref_period(2, 60);
    chk("avg.one_result", obs2.size(), 1);
    expect_res(2, "avg", 60, 1'b0, -2, 1'b0);

    // randomized periods against the model
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    obs0.delete();
    target0 = 8'($urandom_range(40, 100));
    tol0    = 8'($urandom_range(0, 3));
    cycles(3);
    active = 1'b0;
    last   = 0;
    mdl_lc = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) n = $urandom_range(200, 300);
      else n = int'(target0) + $urandom_range(0, 8) - 4;
      if (active) exp0.push_back(model_result(last, int'(target0), int'(tol0)));
      active = 1'b1;
      last   = n;
      ref_period(0, n);
    end
    exp0.push_back(model_result(last, int'(target0), int'(tol0)));
    ref_period(0, 20);
    cycles(5);
    chk("rand.num_results", obs0.size(), exp0.size());
    while (exp0.size() > 0 && obs0.size() > 0) begin
      e = exp0.pop_front();
      g = obs0.pop_front();
      chk("rand.count", g.count, e.count);
      chk("rand.ovf", int'(g.ovf), int'(e.ovf));
      chk("rand.err", g.err, e.err);
      chk("rand.locked", int'(g.locked), int'(e.locked));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_freq_meter.md
Name: pll_freq_meter

Overview:
- Parametrised successor to the PLL feedback counter. Measures how many clk_out cycles occur per clk_ref period.
- clk_ref is treated as asynchronous data and brought into the clk_out domain through a synchronizer, which removes the raw-sampling CDC hazard.
- Optionally averages over 2^AVG_LOG2 reference periods, saturates instead of wrapping, and reports a signed frequency error against a target plus a lock indication for the EPU/loop controller.

Parameters:
- COUNT_W, 8: width of the count/target/tolerance fields.
- SYNC_STAGES, 2: flops in the clk_ref synchronizer (legal range 2-4).
- AVG_LOG2, 0: log2 of the number of ref periods per measurement window (legal range 0-4).
- LOCK_N, 4: number of consecutive in-tolerance results required to assert locked (legal range 1-15).

Ports:
- clk_out, in, 1: measured PLL output clock; the only clock of the block.
- rst, in, 1: asynchronous active-high reset.
- enable, in, 1: measurement enable.
- clk_ref, in, 1: reference clock, sampled as asynchronous data.
- target, in, COUNT_W: expected count per ref period; quasi-static.
- tol, in, COUNT_W: allowed |count-target|; quasi-static.
- count, out, COUNT_W: last averaged measurement.
- count_valid, out, 1: one-cycle pulse when count/error/overflow update.
- overflow, out, 1: last result saturated.
- error, out, COUNT_W+1: signed count-target, two's complement.
- locked, out, 1: frequency lock indication.

Behaviour:
- Reset (async, rst=1): all synchronizer flops, edge-detect flop, acc, prd_cnt and lock_cnt go to 0; FSM=IDLE; count=0, count_valid=0, overflow=0, error=0, locked=0.
- Synchronizer: SYNC_STAGES flops clocked by clk_out. It keeps running when enable=0.
- ref_rise = sync_out & ~sync_out_d. A raw clk_ref edge is seen SYNC_STAGES+1 clk_out edges later, ±1 cycle of uncertainty.
- Accumulator acc is COUNT_W+AVG_LOG2 bits wide and saturating. When it holds all-ones it stays there and sets the internal sat flag.
- FSM IDLE: acc=0, nothing is counted.
  - On ref_rise with enable=1: acc<=1, prd_cnt<=0, sat<=0, go to MEASURE.
  - The partial window before the first rise is always discarded.
- FSM MEASURE, each enabled cycle:
  - Non-rise cycle: acc<=acc+1 (saturating).
  - ref_rise with prd_cnt<2^AVG_LOG2-1: prd_cnt++, acc<=acc+1.
  - ref_rise with prd_cnt==2^AVG_LOG2-1 (window end):
    - count <= sat ? all-ones : acc[top COUNT_W bits], i.e. acc>>AVG_LOG2, truncating.
    - overflow <= sat; error <= count_new - target, computed at COUNT_W+1 bits.
    - count_valid=1 for exactly this one cycle.
    - acc<=1, prd_cnt<=0, sat<=0. Stay in MEASURE.
  - Result: for consecutive rises at cycles t0 and t1 with AVG_LOG2=0, count = t1-t0.
- Lock, evaluated on every count_valid:
  - In tolerance means !overflow_new and |count_new-target| <= tol.
  - In tolerance: lock_cnt saturates-increments; locked<=1 when the new lock_cnt reaches LOCK_N.
  - Out of tolerance: lock_cnt<=0 and locked<=0 in the same cycle count updates.
- enable=0:
  - FSM->IDLE, acc/prd_cnt/lock_cnt cleared, locked<=0.
  - count, error and overflow hold; count_valid=0.
  - On re-enable, measurement restarts at the next ref_rise (first result 2^AVG_LOG2 periods later).
- rst asserted mid-window: everything returns to reset values immediately; no partial result is ever emitted.
- A ref_rise in the same cycle as acc saturating: the window still ends and overflow=1.

Test Plan:
- AVG_LOG2=0, clk_ref period = 60 clk_out cycles: first count_valid after the second detected rise, count=60, error=0 with target=60, overflow=0; no count_valid after the first rise.
- AVG_LOG2=2, ref periods 60,61,60,61: one count_valid after 4 periods, acc=242, count=60 (truncated), error=-2 with target=62.
- COUNT_W=8, AVG_LOG2=0, ref period 300 cycles: count=255, overflow=1, locked stays or drops to 0, lock_cnt=0.
- target=60, tol=1, LOCK_N=4, results 60,61,59,60: locked rises in the cycle of the 4th count_valid. Next result 63 gives locked=0 in that same cycle.
- rst pulsed mid-window (acc≈30): all outputs return to 0 asynchronously. After release, the first count_valid appears only after two full ref periods, with count=60.
- enable dropped for 100 cycles while locked: locked=0, count holds 60. After re-enable, the first result arrives one full window after the first ref_rise, with no spurious count_valid.
